// File: rtl/iob_eth_tx_buf_if.sv
// iob_eth_tx_buf_if: signal bundle between the payload source, the TX frame buffer and the Ethernet transmitter
//  Parameter BUF_ADDR_W must match the buffer instance it is bound to.
//  Stream side : s_data, s_valid, s_last (to buffer), s_ready (from buffer)
//  Transmitter : rd_addr, tx_ready (to buffer); rd_data, tx_nbytes, tx_send (from buffer)
//  Status      : frames_pending, overflow (from buffer)
//  Modports    : slave = the buffer, master = its environment
interface iob_eth_tx_buf_if #(
    parameter int BUF_ADDR_W = 11
);
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [BUF_ADDR_W-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic [15:0]           tx_nbytes;
    logic                  tx_send;
    logic                  tx_ready;
    logic [1:0]            frames_pending;
    logic                  overflow;
    modport slave (
        input  s_data, s_valid, s_last, rd_addr, tx_ready,
        output s_ready, rd_data, tx_nbytes, tx_send, frames_pending, overflow
    );
    modport master (
        output s_data, s_valid, s_last, rd_addr, tx_ready,
        input  s_ready, rd_data, tx_nbytes, tx_send, frames_pending, overflow
    );
endinterface

// File: rtl/iob_eth_tx_buf.sv
// iob_eth_tx_buf: ping-pong frame buffer and launch scheduler feeding the Ethernet transmitter (TX_CLK domain)
//  Ports:
//   TX_CLK  transmit clock
//   tx_rst  asynchronous active-high reset
//   bus     iob_eth_tx_buf_if.slave: payload stream in, transmitter send/nbytes/read port, status
//  Optional feature: define ETH_TX_PAD_EN to pad short frames to the 46-byte minimum payload.
module iob_eth_tx_buf #(
    parameter int BUF_ADDR_W = 11,
    parameter int IFG_CYCLES = 24
) (
    input logic               TX_CLK,
    input logic               tx_rst,
    iob_eth_tx_buf_if.slave   bus
);
    localparam int DEPTH = 2 ** BUF_ADDR_W;
    localparam logic [BUF_ADDR_W-1:0] MAX_LEN = '1;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_START, WAIT_DONE, IFG} state_t;
    state_t                r_state, w_next;
    logic [7:0]            r_mem [0:2*DEPTH-1];
    logic [BUF_ADDR_W-1:0] r_len [2];
    logic [1:0]            r_full;
    logic                  r_wr_bank, r_rd_bank;
    logic [BUF_ADDR_W-1:0] r_wptr;
    logic [15:0]           r_nbytes, r_cnt;
    logic                  r_repulsed, r_overflow;
    logic                  w_accept, w_room, w_close, w_release, w_launch;
    logic [1:0]            w_set, w_clr;
    logic [BUF_ADDR_W-1:0] w_waddr, w_close_len;
    logic [15:0]           w_len16, w_nbytes;
    logic [7:0]            w_ram_rd;
    assign w_accept    = bus.s_valid & bus.s_ready;
    // Address 0 is unused, so a bank holds at most MAX_LEN bytes; beyond that beats are swallowed.
    assign w_room      = r_wptr != MAX_LEN;
    assign w_close     = w_accept & bus.s_last;
    assign w_waddr     = r_wptr + BUF_ADDR_W'(1);
    assign w_close_len = w_room ? w_waddr : MAX_LEN;
    assign w_set       = {w_close & r_wr_bank, w_close & ~r_wr_bank};
    assign w_clr       = {w_release & r_rd_bank, w_release & ~r_rd_bank};
    assign w_launch    = (r_state == IDLE) && (w_next == SEND);
    assign w_len16     = 16'(r_len[r_rd_bank]);
    assign w_ram_rd    = r_mem[{r_rd_bank, bus.rd_addr}];
`ifdef ETH_TX_PAD_EN
    assign w_nbytes    = (w_len16 < 16'd46) ? 16'd46 : w_len16;
    assign bus.rd_data = (bus.rd_addr > r_len[r_rd_bank]) ? 8'h00 : w_ram_rd;
`else
    assign w_nbytes    = w_len16;
    assign bus.rd_data = w_ram_rd;
`endif
    assign bus.s_ready        = ~r_full[r_wr_bank];
    assign bus.tx_send        = r_state == SEND;
    assign bus.tx_nbytes      = r_nbytes;
    assign bus.frames_pending = {1'b0, r_full[0]} + {1'b0, r_full[1]};
    assign bus.overflow       = r_overflow;
    // Storage carries no reset: contents are meaningless until a frame is written.
    always_ff @(posedge TX_CLK) begin
        if (w_accept && w_room) r_mem[{r_wr_bank, w_waddr}] <= bus.s_data;
        if (w_close) r_len[r_wr_bank] <= w_close_len;
    end
    always_ff @(posedge TX_CLK or posedge tx_rst) begin
        if (tx_rst) begin
            r_state    <= IDLE;
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wptr     <= '0;
            r_nbytes   <= '0;
            r_cnt      <= '0;
            r_repulsed <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            // Set (write side) and release (launch side) always target different banks.
            r_full  <= (r_full | w_set) & ~w_clr;
            if (w_accept) begin
                r_wptr <= bus.s_last ? '0 : (w_room ? w_waddr : r_wptr);
                if (!w_room) r_overflow <= 1'b1;
                if (bus.s_last) r_wr_bank <= ~r_wr_bank;
            end
            if (w_launch) r_nbytes <= w_nbytes;
            if (w_release) r_rd_bank <= ~r_rd_bank;
            // Cycles spent in the current state; restarts on every state change.
            r_cnt      <= (r_state == w_next) ? r_cnt + 16'd1 : 16'd0;
            r_repulsed <= (r_state == IDLE) ? 1'b0 : r_repulsed | ((r_state == WAIT_START) && (w_next == SEND));
        end
    end
    always_comb begin
        w_next    = r_state;
        w_release = 1'b0;
        case (r_state)
            IDLE:       if (r_full[r_rd_bank] && bus.tx_ready) w_next = SEND;
            SEND:       w_next = WAIT_START;
            // A transmitter that never acknowledges gets exactly one retry after 8 cycles.
            WAIT_START: if (!bus.tx_ready) w_next = WAIT_DONE;
                        else if (r_cnt == 16'd7 && !r_repulsed) w_next = SEND;
            WAIT_DONE:  if (bus.tx_ready) w_next = IFG;
            IFG:        if (r_cnt == 16'(IFG_CYCLES - 1)) begin
                            w_next    = IDLE;
                            w_release = 1'b1;
                        end
            default:    w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_iob_eth_tx_buf.sv
// tb_iob_eth_tx_buf: scoreboard bench for the ping-pong TX frame buffer with a behavioural transmitter model
module tb_iob_eth_tx_buf;
    localparam int AW   = 7;
    localparam int IFG  = 24;
    localparam int MAXL = (1 << AW) - 1;
`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    typedef struct {int len; int nb; bit lat; bit hold;} exp_t;
    logic       TX_CLK = 1'b0;
    logic       tx_rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    bit         exp_ovf = 1'b0;
    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    logic [8:0] stim_q[$];
    iob_eth_tx_buf_if #(.BUF_ADDR_W(AW)) bus ();
    iob_eth_tx_buf #(.BUF_ADDR_W(AW), .IFG_CYCLES(IFG)) dut (
        .TX_CLK (TX_CLK),
        .tx_rst (tx_rst),
        .bus    (bus)
    );
    always #5 TX_CLK = ~TX_CLK;
    always @(posedge TX_CLK) cyc <= cyc + 1;
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not end, errors %0d", errors);
        $fatal(1, "watchdog");
    end
    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask
    task automatic check_reset();
        chk("rst_s_ready", int'(bus.s_ready), 1);
        chk("rst_tx_send", int'(bus.tx_send), 0);
        chk("rst_tx_nbytes", int'(bus.tx_nbytes), 0);
        chk("rst_frames_pending", int'(bus.frames_pending), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
    endtask
    // Reference model: a frame of n bytes keeps its first min(n,MAXL) bytes.
    task automatic push_frame(int n, bit incr, bit lat, bit hold);
        exp_t e;
        int len;
        len    = n > MAXL ? MAXL : n;
        e.len  = len;
        e.nb   = (PAD && len < 46) ? 46 : len;
        e.lat  = lat;
        e.hold = hold;
        exp_q.push_back(e);
        if (n > MAXL) exp_ovf = 1'b1;
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = incr ? 8'(k) : 8'($urandom);
            if (k < len) byte_q.push_back(b);
            stim_q.push_back({k == n - 1, b});
        end
    endtask
    task automatic drive_all();
        logic [8:0] v;
        int w;
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            @(negedge TX_CLK);
            while ($urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                @(negedge TX_CLK);
            end
            bus.s_data  = v[7:0];
            bus.s_last  = v[8];
            bus.s_valid = 1'b1;
            w = 0;
            while (!bus.s_ready && w < 4000) begin
                @(negedge TX_CLK);
                w++;
            end
            if (!bus.s_ready) begin
                chk("s_ready_timeout", 0, 1);
                stim_q.delete();
                break;
            end
            if (v[8]) last_cyc = cyc;
        end
        @(negedge TX_CLK);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask
    // Transmitter model plus checker: pops one expectation per launch.
    task automatic monitor(int nf);
        exp_t e;
        int rise, w, pulses, hold, expb;
        rise = -100000;
        for (int f = 0; f < nf; f++) begin
            bus.tx_ready = 1'b1;
            w = 0;
            do begin
                @(negedge TX_CLK);
                w++;
            end while (!bus.tx_send && w < 4000);
            if (!bus.tx_send) begin
                chk("send_timeout", 0, 1);
                return;
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_send", 1, 0);
                return;
            end
            e = exp_q.pop_front();
            checks++;
            if (cyc - rise < IFG) begin
                errors++;
                $display("FAIL ifg_gap: got %0d cycles required >= %0d", cyc - rise, IFG);
            end
            chk("tx_nbytes", int'(bus.tx_nbytes), e.nb);
            if (e.lat) chk("send_latency", cyc - last_cyc, 2);
            pulses = 1;
            hold   = e.hold ? 12 : $urandom_range(1, 3);
            for (int i = 0; i < hold; i++) begin
                @(negedge TX_CLK);
                if (bus.tx_send) pulses++;
            end
            bus.tx_ready = 1'b0;
            for (int k = 1; k <= e.nb; k++) begin
                bus.rd_addr = AW'(k);
                #1;
                expb = (k <= e.len) ? int'(byte_q.pop_front()) : 0;
                chk("rd_data", int'(bus.rd_data), expb);
                for (int h = 0; h < 2; h++) begin
                    @(negedge TX_CLK);
                    if (bus.tx_send) pulses++;
                end
            end
            bus.tx_ready = 1'b1;
            rise = cyc;
            chk("send_pulses", pulses, e.hold ? 2 : 1);
        end
    endtask
    task automatic run(int nf);
        fork
            drive_all();
            monitor(nf);
        join
        repeat (IFG + 5) @(negedge TX_CLK);
        chk("idle_frames_pending", int'(bus.frames_pending), 0);
        chk("overflow_flag", int'(bus.overflow), int'(exp_ovf));
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask
    task automatic quiet(int n);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge TX_CLK);
            if (bus.tx_send) p++;
        end
        chk("no_send_after_rst", p, 0);
    endtask
    initial begin
        int w;
        bus.s_data   = '0;
        bus.s_valid  = 1'b0;
        bus.s_last   = 1'b0;
        bus.rd_addr  = '0;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge TX_CLK);
        check_reset();
        tx_rst = 1'b0;
        // 64-byte incrementing frame, launch latency and first byte
        push_frame(64, 1'b1, 1'b1, 1'b0);
        run(1);
        // two 100-byte frames while the transmitter is busy
        bus.tx_ready = 1'b0;
        push_frame(100, 1'b0, 1'b0, 1'b0);
        push_frame(100, 1'b0, 1'b0, 1'b0);
        drive_all();
        @(negedge TX_CLK);
        chk("both_full_s_ready", int'(bus.s_ready), 0);
        chk("both_full_pending", int'(bus.frames_pending), 2);
        run(2);
        // short frame, overflow frame followed by a normal one, re-pulse frame, random mix
        push_frame(10, 1'b1, 1'b0, 1'b0);
        push_frame(140, 1'b0, 1'b0, 1'b0);
        push_frame(20, 1'b0, 1'b0, 1'b0);
        push_frame(30, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) push_frame($urandom_range(1, 140), 1'b0, 1'b0, 1'b0);
        run(14);
        // reset in the middle of a frame
        @(negedge TX_CLK);
        bus.s_valid = 1'b1;
        bus.s_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.s_data = 8'($urandom);
            @(negedge TX_CLK);
        end
        #2 tx_rst = 1'b1;
        #1 check_reset();
        exp_ovf     = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge TX_CLK);
        tx_rst = 1'b0;
        quiet(60);
        // reset while the transmitter is sending
        push_frame(30, 1'b0, 1'b0, 1'b0);
        drive_all();
        w = 0;
        while (!bus.tx_send && w < 100) begin
            @(negedge TX_CLK);
            w++;
        end
        chk("wd_send_seen", int'(bus.tx_send), 1);
        bus.tx_ready = 1'b0;
        repeat (5) @(negedge TX_CLK);
        #2 tx_rst = 1'b1;
        #1 check_reset();
        exp_q.delete();
        byte_q.delete();
        exp_ovf      = 1'b0;
        bus.tx_ready = 1'b1;
        @(negedge TX_CLK);
        tx_rst = 1'b0;
        quiet(60);
        push_frame(25, 1'b0, 1'b0, 1'b0);
        run(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
